grid_cell_decoder: RTL and testbench



---
 rtl/maze_pkg.sv | 23 ++
 rtl/grid_neighbour.sv | 54 +++++
 rtl/grid_cell_decoder.sv | 150 +++++++++++++++
 tb/tb_grid_cell_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg
// Shared definitions for the maze agent datapath.
//   DIR_*        : move direction encoding on move_dir
//   state_t      : episode state of grid_cell_decoder
//   cell_idx_w() : width of a cell index able to hold 0 (no cell) .. n
package maze_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cell_idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/grid_neighbour.sv
// grid_neighbour
// Combinational neighbour lookup on a ROWS x COLS grid with 1-based cell
// numbering (cell k at row (k-1)/COLS, col (k-1)%COLS).
// Ports:
//   at       in  IW  current cell index (1..ROWS*COLS)
//   move_dir in  2   DIR_UP / DIR_RIGHT / DIR_DOWN / DIR_LEFT
//   target   out IW  neighbouring cell index (equals at when off_grid)
//   off_grid out 1   the move would leave the grid
module grid_neighbour
  import maze_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int IW   = cell_idx_w(ROWS * COLS)
) (
  input  logic [IW-1:0] at,
  input  logic [1:0]    move_dir,
  output logic [IW-1:0] target,
  output logic          off_grid
);

  logic [IW-1:0] idx0;
  logic [IW-1:0] row;
  logic [IW-1:0] col;

  // Zero-based position; only meaningful while at is a real cell.
  assign idx0 = at - IW'(1);
  assign row  = idx0 / IW'(COLS);
  assign col  = idx0 % IW'(COLS);

  always_comb begin
    target   = at;
    off_grid = 1'b0;
    case (move_dir)
      DIR_UP: begin
        if (row == '0) off_grid = 1'b1;
        else           target   = at - IW'(COLS);
      end
      DIR_RIGHT: begin
        if (col == IW'(COLS - 1)) off_grid = 1'b1;
        else                      target   = at + IW'(1);
      end
      DIR_DOWN: begin
        if (row == IW'(ROWS - 1)) off_grid = 1'b1;
        else                      target   = at + IW'(COLS);
      end
      default: begin // DIR_LEFT
        if (col == '0) off_grid = 1'b1;
        else           target   = at - IW'(1);
      end
    endcase
  end

endmodule

// File: rtl/grid_cell_decoder.sv
// grid_cell_decoder
// Tracks the agent's cell on a ROWS x COLS grid and drives a registered
// one-hot enable bus (one bit per cell) to the per-cell Q-value banks.
// Moves at grid edges or into WALLS cells are blocked (bumped pulse);
// reaching GOAL_CELL or MAX_STEPS accepted moves ends the episode.
//
// Handshake: a move is taken on a rising edge where move_valid && move_ready.
// move_ready is high exactly while in RUN and depends only on state. A start
// pulse in the same cycle wins: the move is dropped and not counted.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin/restart an episode (single-cycle pulse)
//   move_valid  move command valid
//   move_dir    0=up 1=right 2=down 3=left
//   move_ready  move can be accepted (RUN only)
//   at          current cell index, 0 = no cell
//   en          registered one-hot enable, en[k-1] high when at==k
//   bumped      one-cycle pulse: last accepted move was blocked
//   goal_hit    level: episode ended on GOAL_CELL
//   timeout     level: episode ended on MAX_STEPS
//   step_count  accepted moves this episode, saturating
//   dbg_state   current FSM state (state_t encoding)
module grid_cell_decoder
  import maze_pkg::*;
#(
  parameter int                       ROWS       = 4,
  parameter int                       COLS       = 4,
  parameter int                       START_CELL = 1,
  parameter int                       GOAL_CELL  = 16,
  parameter logic [ROWS*COLS-1:0]     WALLS      = '0,
  parameter int                       STEP_W     = 8,
  parameter int                       MAX_STEPS  = 200,
  localparam int                      N          = ROWS * COLS,
  localparam int                      IW         = cell_idx_w(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              move_valid,
  input  logic [1:0]        move_dir,
  output logic              move_ready,
  output logic [IW-1:0]     at,
  output logic [N-1:0]      en,
  output logic              bumped,
  output logic              goal_hit,
  output logic              timeout,
  output logic [STEP_W-1:0] step_count,
  output logic [1:0]        dbg_state
);

  localparam logic [IW-1:0]     START_IW = IW'(START_CELL);
  localparam logic [IW-1:0]     GOAL_IW  = IW'(GOAL_CELL);
  localparam logic [STEP_W-1:0] MAX_SW   = STEP_W'(MAX_STEPS);

  state_t              state, state_n;
  logic [IW-1:0]       at_n;
  logic [N-1:0]        en_n;
  logic [STEP_W-1:0]   cnt_n, cnt_inc;
  logic                bump_n, goal_n, to_n;
  logic [IW-1:0]       target;
  logic                off_grid;
  logic                wall_hit;
  logic                blocked;
  logic                accept;

  grid_neighbour #(
    .ROWS (ROWS),
    .COLS (COLS),
    .IW   (IW)
  ) u_nb (
    .at       (at),
    .move_dir (move_dir),
    .target   (target),
    .off_grid (off_grid)
  );

  assign move_ready = (state == RUN);
  assign accept     = move_valid && move_ready && !start;
  assign dbg_state  = state;

  // Wall lookup by compare rather than WALLS[target-1], so an off-grid
  // target can never form an out-of-range index.
  always_comb begin
    wall_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (target == IW'(k + 1)) wall_hit = WALLS[k];
    end
  end

  assign blocked = off_grid || wall_hit;
  assign cnt_inc = (step_count == '1) ? step_count : step_count + STEP_W'(1);

  always_comb begin
    state_n = state;
    at_n    = at;
    cnt_n   = step_count;
    bump_n  = 1'b0;
    goal_n  = goal_hit;
    to_n    = timeout;
    if (start) begin
      state_n = RUN;
      at_n    = START_IW;
      cnt_n   = '0;
      goal_n  = 1'b0;
      to_n    = 1'b0;
    end else if (accept) begin
      cnt_n = cnt_inc;
      if (blocked) bump_n = 1'b1;
      else         at_n   = target;
      // Goal is checked first so a goal on the final allowed step wins.
      if (!blocked && target == GOAL_IW) begin
        state_n = DONE;
        goal_n  = 1'b1;
      end else if (cnt_inc == MAX_SW) begin
        state_n = DONE;
        to_n    = 1'b1;
      end
    end
  end

  // en is decoded from the next cell so it lines up with at after the edge.
  always_comb begin
    en_n = '0;
    for (int k = 0; k < N; k++) begin
      if (at_n == IW'(k + 1)) en_n[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      at         <= '0;
      en         <= '0;
      step_count <= '0;
      bumped     <= 1'b0;
      goal_hit   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      at         <= at_n;
      en         <= en_n;
      step_count <= cnt_n;
      bumped     <= bump_n;
      goal_hit   <= goal_n;
      timeout    <= to_n;
    end
  end

endmodule

// File: tb/tb_grid_cell_decoder.sv
module tb_grid_cell_decoder;

  localparam int UP = 0, RT = 1, DN = 2, LF = 3;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic move_valid;
  logic [1:0] move_dir;

  logic        rdy_o  [NI];
  logic [4:0]  at_o   [NI];
  logic [15:0] en_o   [NI];
  logic        bmp_o  [NI];
  logic        goal_o [NI];
  logic        to_o   [NI];
  logic [7:0]  cnt_o  [NI];
  logic [1:0]  dbg_o  [NI];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // d0: defaults; d1: cell 2 is a wall; d2: MAX_STEPS = 3
  grid_cell_decoder dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid),
    .move_dir(move_dir), .move_ready(rdy_o[0]), .at(at_o[0]), .en(en_o[0]),
    .bumped(bmp_o[0]), .goal_hit(goal_o[0]), .timeout(to_o[0]),
    .step_count(cnt_o[0]), .dbg_state(dbg_o[0]));

  grid_cell_decoder #(.WALLS(16'h0002)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid),
    .move_dir(move_dir), .move_ready(rdy_o[1]), .at(at_o[1]), .en(en_o[1]),
    .bumped(bmp_o[1]), .goal_hit(goal_o[1]), .timeout(to_o[1]),
    .step_count(cnt_o[1]), .dbg_state(dbg_o[1]));

  grid_cell_decoder #(.MAX_STEPS(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid),
    .move_dir(move_dir), .move_ready(rdy_o[2]), .at(at_o[2]), .en(en_o[2]),
    .bumped(bmp_o[2]), .goal_hit(goal_o[2]), .timeout(to_o[2]),
    .step_count(cnt_o[2]), .dbg_state(dbg_o[2]));

  // ---------------- reference model (row/col arithmetic) ----------------
  // m_ph: 0 = idle, 1 = running, 2 = finished
  int m_ph [NI], m_at [NI], m_cnt [NI];
  bit m_b [NI], m_g [NI], m_t [NI];
  int m_wall [NI] = '{0, 2, 0};
  int m_max  [NI] = '{200, 200, 3};

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_ph[i] = 0; m_at[i] = 0; m_cnt[i] = 0;
      m_b[i] = 0; m_g[i] = 0; m_t[i] = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit v, input int d);
    int r, c, t;
    for (int i = 0; i < NI; i++) begin
      m_b[i] = 0;
      if (s) begin
        m_ph[i] = 1; m_at[i] = 1; m_cnt[i] = 0; m_g[i] = 0; m_t[i] = 0;
      end else if (m_ph[i] == 1 && v) begin
        m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
        r = (m_at[i] - 1) / 4;
        c = (m_at[i] - 1) % 4;
        if (d == UP) r--; else if (d == RT) c++; else if (d == DN) r++; else c--;
        t = r * 4 + c + 1;
        if (r < 0 || r > 3 || c < 0 || c > 3 || ((m_wall[i] >> (t - 1)) & 1) != 0) begin
          m_b[i] = 1;
        end else begin
          m_at[i] = t;
        end
        if (!m_b[i] && m_at[i] == 16) begin
          m_ph[i] = 2; m_g[i] = 1;
        end else if (m_cnt[i] == m_max[i]) begin
          m_ph[i] = 2; m_t[i] = 1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int e;
    for (int i = 0; i < NI; i++) begin
      e = (m_at[i] == 0) ? 0 : (1 << (m_at[i] - 1));
      chk($sformatf("%s d%0d at", tag, i), int'(at_o[i]), m_at[i]);
      chk($sformatf("%s d%0d en", tag, i), int'(en_o[i]), e);
      chk($sformatf("%s d%0d ready", tag, i), int'(rdy_o[i]), int'(m_ph[i] == 1));
      chk($sformatf("%s d%0d bumped", tag, i), int'(bmp_o[i]), int'(m_b[i]));
      chk($sformatf("%s d%0d goal", tag, i), int'(goal_o[i]), int'(m_g[i]));
      chk($sformatf("%s d%0d timeout", tag, i), int'(to_o[i]), int'(m_t[i]));
      chk($sformatf("%s d%0d steps", tag, i), int'(cnt_o[i]), m_cnt[i]);
      chk($sformatf("%s d%0d state", tag, i), int'(dbg_o[i]), m_ph[i]);
    end
  endtask

  // Called at a negedge: drive, take one rising edge, sample at next negedge.
  task automatic cycle(input bit s, input bit v, input int d);
    start = s; move_valid = v; move_dir = 2'(d);
    @(posedge clk);
    model_edge(s, v, d);
    @(negedge clk);
    start = 1'b0; move_valid = 1'b0;
  endtask

  // ---------------- directed table (expectations for dut0) ----------------
  typedef struct {
    bit s; bit v; int d;
    int at; int steps; bit b; bit g; bit r;
  } vec_t;
  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1, 0, UP, 1,  0, 0, 0, 1};  // start
    tbl[1]  = '{0, 1, RT, 2,  1, 0, 0, 1};
    tbl[2]  = '{0, 1, DN, 6,  2, 0, 0, 1};
    tbl[3]  = '{0, 1, DN, 10, 3, 0, 0, 1};
    tbl[4]  = '{0, 1, DN, 14, 4, 0, 0, 1};
    tbl[5]  = '{0, 1, RT, 15, 5, 0, 0, 1};
    tbl[6]  = '{0, 1, RT, 16, 6, 0, 1, 0};  // goal reached
    tbl[7]  = '{0, 1, RT, 16, 6, 0, 1, 0};  // ignored in DONE
    tbl[8]  = '{1, 0, UP, 1,  0, 0, 0, 1};  // restart
    tbl[9]  = '{0, 1, UP, 1,  1, 1, 0, 1};  // top edge
    tbl[10] = '{0, 1, LF, 1,  2, 1, 0, 1};  // left edge
    tbl[11] = '{0, 0, UP, 1,  2, 0, 0, 1};  // bump pulse clears
    tbl[12] = '{1, 1, RT, 1,  0, 0, 0, 1};  // start beats move
    tbl[13] = '{0, 1, UP, 1,  1, 1, 0, 1};

    rst_n = 1'b0; start = 1'b0; move_valid = 1'b0; move_dir = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_model("reset");
    rst_n = 1'b1;
    cycle(0, 1, RT);                      // IDLE ignores moves
    check_model("idle");

    for (int j = 0; j < 14; j++) begin
      cycle(tbl[j].s, tbl[j].v, tbl[j].d);
      chk($sformatf("tbl%0d at", j), int'(at_o[0]), tbl[j].at);
      chk($sformatf("tbl%0d steps", j), int'(cnt_o[0]), tbl[j].steps);
      chk($sformatf("tbl%0d bumped", j), int'(bmp_o[0]), int'(tbl[j].b));
      chk($sformatf("tbl%0d goal", j), int'(goal_o[0]), int'(tbl[j].g));
      chk($sformatf("tbl%0d ready", j), int'(rdy_o[0]), int'(tbl[j].r));
      check_model($sformatf("tbl%0d", j));
    end

    // After rows 12/13 plus two earlier bumps dut2 has made 3 blocked moves?
    // Row 12 restarted it, row 13 is move 1; two more blocked moves time out.
    cycle(0, 1, LF);
    cycle(0, 1, UP);
    chk("walls bump right", 0, 0 + int'(at_o[1] != 5'd1));
    chk("to timeout", int'(to_o[2]), 1);
    chk("to goal", int'(goal_o[2]), 0);
    chk("to at", int'(at_o[2]), 1);
    chk("to ready", int'(rdy_o[2]), 0);
    chk("to steps", int'(cnt_o[2]), 3);
    check_model("timeout");
    cycle(1, 0, UP);
    chk("restart timeout", int'(to_o[2]), 0);
    chk("restart steps", int'(cnt_o[2]), 0);
    chk("restart ready", int'(rdy_o[2]), 1);
    cycle(0, 1, RT);
    chk("wall right at", int'(at_o[1]), 1);
    chk("wall right bumped", int'(bmp_o[1]), 1);
    check_model("wall");

    // Asynchronous reset mid-move at cell 6
    cycle(1, 0, UP);
    cycle(0, 1, RT);
    cycle(0, 1, DN);
    chk("pre-reset at", int'(at_o[0]), 6);
    start = 1'b0; move_valid = 1'b1; move_dir = 2'(RT);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async reset");
    @(negedge clk);
    check_model("held reset");
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cycle(0, 1, $urandom_range(0, 3));
      check_model("post-reset idle");
    end

    // Randomized stimulus against the model
    for (int j = 0; j < 600; j++) begin
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3));
      check_model($sformatf("rand%0d", j));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
